// File: rtl/tnoc_vc_scheduler_if.sv
// Flit ingress/egress bundle for the virtual-channel scheduler.
// The scheduler takes the slave side and the traffic source/sink takes the master side.
interface tnoc_vc_scheduler_if #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned FLIT_WIDTH = 64,
    parameter int unsigned VC_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                  i_valid;
    logic [VC_WIDTH-1:0]   i_vc;
    logic                  i_head;
    logic                  i_tail;
    logic [FLIT_WIDTH-1:0] i_flit;
    logic [CHANNELS-1:0]   o_ready;
    logic [CHANNELS-1:0]   o_almost_full;
    logic                  o_valid;
    logic                  i_ready;
    logic [VC_WIDTH-1:0]   o_vc;
    logic                  o_head;
    logic                  o_tail;
    logic [FLIT_WIDTH-1:0] o_flit;
    logic                  o_error;

    modport master (
        output i_valid, i_vc, i_head, i_tail, i_flit, i_ready,
        input  o_ready, o_almost_full, o_valid, o_vc, o_head, o_tail, o_flit, o_error
    );

    modport slave (
        input  i_valid, i_vc, i_head, i_tail, i_flit, i_ready,
        output o_ready, o_almost_full, o_valid, o_vc, o_head, o_tail, o_flit, o_error
    );
endinterface

// File: rtl/tnoc_vc_scheduler.sv
// Per-VC flit FIFOs feeding one output port, with packet-locked round-robin or
// fixed-priority arbitration and error pulses for dropped or orphaned flits.
module tnoc_vc_scheduler #(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned FLIT_WIDTH     = 64,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned FIFO_THRESHOLD = FIFO_DEPTH - 2,
    parameter int unsigned ARB_MODE       = 0
) (
    input logic                clk,
    input logic                rst_n,
    tnoc_vc_scheduler_if.slave bus
);
    localparam int unsigned VC_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENTRY_W  = FLIT_WIDTH + 2;

    typedef enum logic [0:0] {StUnlocked, StLocked} arb_state_e;

    logic [CHANNELS-1:0]   push;
    logic [CHANNELS-1:0]   pop;
    logic [CHANNELS-1:0]   not_empty;
    logic [CHANNELS-1:0]   full;
    logic [CHANNELS-1:0]   almost_full;
    logic [CHANNELS-1:0]   front_head;
    logic [CHANNELS-1:0]   front_tail;
    logic [FLIT_WIDTH-1:0] front_flit [CHANNELS];
    logic [CHANNELS-1:0]   eligible;
    logic [CHANNELS-1:0]   discard;
    logic [ENTRY_W-1:0]    entry_in;
    logic                  vc_in_range;

    arb_state_e          state_q, state_d;
    logic [VC_WIDTH-1:0] lock_vc_q, lock_vc_d;
    logic [VC_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [VC_WIDTH-1:0] sel_vc;
    logic [VC_WIDTH-1:0] start_vc;
    logic                out_valid;
    logic                transfer;
    logic                error_q, error_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign entry_in    = {bus.i_head, bus.i_tail, bus.i_flit};
    assign vc_in_range = (32'(bus.i_vc) < CHANNELS);

    // Readiness comes only from the registered count, so a full FIFO refuses a
    // push even when it pops in the same cycle.
    always_comb begin
        push = '0;
        if (bus.i_valid && vc_in_range && !full[bus.i_vc]) begin
            push[bus.i_vc] = 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
        logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]   count_q, count_d;

        always_comb begin
            wr_ptr_d = push[c] ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_d = pop[c] ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            count_d  = count_q;
            if (push[c] && !pop[c]) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push[c] && pop[c]) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // Payload storage needs no reset: the counts gate every read.
        always_ff @(posedge clk) begin
            if (push[c]) begin
                mem_q[wr_ptr_q] <= entry_in;
            end
        end

        assign not_empty[c]   = (count_q != '0);
        assign full[c]        = (count_q == CNT_W'(FIFO_DEPTH));
        assign almost_full[c] = (count_q >= CNT_W'(FIFO_THRESHOLD));
        assign {front_head[c], front_tail[c], front_flit[c]} = mem_q[rd_ptr_q];
    end

    assign start_vc = (ARB_MODE == 1) ? '0 : rr_ptr_q;

    always_comb begin
        eligible  = '0;
        discard   = '0;
        sel_vc    = '0;
        out_valid = 1'b0;
        if (state_q == StUnlocked) begin
            eligible = not_empty & front_head;
            discard  = not_empty & ~front_head;
            // First pass covers start_vc and upward, second pass wraps to the low VCs.
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!out_valid && eligible[i] && (VC_WIDTH'(i) >= start_vc)) begin
                    sel_vc    = VC_WIDTH'(i);
                    out_valid = 1'b1;
                end
            end
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!out_valid && eligible[i]) begin
                    sel_vc    = VC_WIDTH'(i);
                    out_valid = 1'b1;
                end
            end
        end else begin
            sel_vc    = lock_vc_q;
            out_valid = not_empty[lock_vc_q];
        end
    end

    assign transfer = out_valid && bus.i_ready;

    always_comb begin
        pop       = discard;
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        if (transfer) begin
            pop[sel_vc] = 1'b1;
        end
        if (out_valid) begin
            if (transfer && front_tail[sel_vc]) begin
                state_d = StUnlocked;
                if (ARB_MODE == 0) begin
                    rr_ptr_d = (sel_vc == VC_WIDTH'(CHANNELS - 1)) ? '0 : sel_vc + VC_WIDTH'(1);
                end
            end else begin
                state_d   = StLocked;
                lock_vc_d = sel_vc;
            end
        end
        error_d = (bus.i_valid && !vc_in_range) || (|discard);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StUnlocked;
            lock_vc_q <= '0;
            rr_ptr_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            rr_ptr_q  <= rr_ptr_d;
            error_q   <= error_d;
        end
    end

    // Zero the data fields when idle so the outputs read as reset values.
    assign bus.o_ready       = ~full;
    assign bus.o_almost_full = almost_full;
    assign bus.o_valid       = out_valid;
    assign bus.o_vc          = out_valid ? sel_vc : '0;
    assign bus.o_head        = out_valid & front_head[sel_vc];
    assign bus.o_tail        = out_valid & front_tail[sel_vc];
    assign bus.o_flit        = out_valid ? front_flit[sel_vc] : '0;
    assign bus.o_error       = error_q;

endmodule

// File: tb/tb_tnoc_vc_scheduler.sv
// Directed bench: round-robin, fixed-priority and 3-VC scheduler instances driven in parallel.
module tb_tnoc_vc_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    tnoc_vc_scheduler_if #(.CHANNELS(2), .FLIT_WIDTH(16), .VC_WIDTH(1)) bus_rr ();
    tnoc_vc_scheduler_if #(.CHANNELS(2), .FLIT_WIDTH(16), .VC_WIDTH(1)) bus_fp ();
    tnoc_vc_scheduler_if #(.CHANNELS(3), .FLIT_WIDTH(16), .VC_WIDTH(2)) bus_c3 ();

    tnoc_vc_scheduler #(
        .CHANNELS(2), .FLIT_WIDTH(16), .FIFO_DEPTH(4), .FIFO_THRESHOLD(2), .ARB_MODE(0)
    ) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));

    tnoc_vc_scheduler #(
        .CHANNELS(2), .FLIT_WIDTH(16), .FIFO_DEPTH(4), .FIFO_THRESHOLD(2), .ARB_MODE(1)
    ) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

    tnoc_vc_scheduler #(
        .CHANNELS(3), .FLIT_WIDTH(16), .FIFO_DEPTH(4), .FIFO_THRESHOLD(2), .ARB_MODE(0)
    ) dut_c3 (.clk(clk), .rst_n(rst_n), .bus(bus_c3));

    task automatic drive(input logic v, input logic [1:0] vc, input logic h, input logic t,
                         input logic [15:0] f);
        bus_rr.i_valid = v; bus_rr.i_vc = vc[0]; bus_rr.i_head = h; bus_rr.i_tail = t;
        bus_rr.i_flit = f;
        bus_fp.i_valid = v; bus_fp.i_vc = vc[0]; bus_fp.i_head = h; bus_fp.i_tail = t;
        bus_fp.i_flit = f;
        bus_c3.i_valid = v; bus_c3.i_vc = vc; bus_c3.i_head = h; bus_c3.i_tail = t;
        bus_c3.i_flit = f;
    endtask

    task automatic set_ready(input logic r);
        bus_rr.i_ready = r;
        bus_fp.i_ready = r;
        bus_c3.i_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
        set_ready(1'b0);
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
        set_ready(1'b0);
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus_rr.o_valid, bus_rr.o_error, bus_rr.o_vc, bus_rr.o_head, bus_rr.o_tail}
            !== 5'b0 || bus_rr.o_flit !== 16'h0)
            $display("FAIL reset_rr_out: valid=%b err=%b vc=%b flit=%h, want all 0",
                     bus_rr.o_valid, bus_rr.o_error, bus_rr.o_vc, bus_rr.o_flit);
        else passes++;
        checks++;
        if (bus_rr.o_ready !== 2'b11 || bus_rr.o_almost_full !== 2'b00)
            $display("FAIL reset_rr_flags: ready=%b af=%b, want 11/00",
                     bus_rr.o_ready, bus_rr.o_almost_full);
        else passes++;
        checks++;
        if (bus_c3.o_ready !== 3'b111 || bus_c3.o_almost_full !== 3'b000 ||
            bus_c3.o_valid !== 1'b0 || bus_c3.o_vc !== 2'b00)
            $display("FAIL reset_c3: ready=%b af=%b valid=%b vc=%b, want 111/000/0/00",
                     bus_c3.o_ready, bus_c3.o_almost_full, bus_c3.o_valid, bus_c3.o_vc);
        else passes++;
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (bus_fp.o_valid !== 1'b0 || bus_fp.o_error !== 1'b0 || bus_fp.o_ready !== 2'b11)
            $display("FAIL reset_fp_after: valid=%b err=%b ready=%b, want 0/0/11",
                     bus_fp.o_valid, bus_fp.o_error, bus_fp.o_ready);
        else passes++;
    endtask

    task automatic test_single_vc();
        do_reset();
        set_ready(1'b1);
        drive(1'b1, 2'd1, 1'b1, 1'b0, 16'h0011);
        checks++;
        if (bus_rr.o_valid !== 1'b0)
            $display("FAIL single_no_bypass: valid=%b, want 0", bus_rr.o_valid);
        else passes++;
        step();
        drive(1'b1, 2'd1, 1'b0, 1'b0, 16'h0022);
        checks++;
        if ({bus_rr.o_valid, bus_rr.o_vc, bus_rr.o_head, bus_rr.o_tail} !== 4'b1110 ||
            bus_rr.o_flit !== 16'h0011)
            $display("FAIL single_head: v/vc/h/t=%b%b%b%b flit=%h, want 1110 0011",
                     bus_rr.o_valid, bus_rr.o_vc, bus_rr.o_head, bus_rr.o_tail, bus_rr.o_flit);
        else passes++;
        step();
        drive(1'b1, 2'd1, 1'b0, 1'b1, 16'h0033);
        checks++;
        if ({bus_rr.o_valid, bus_rr.o_vc, bus_rr.o_head, bus_rr.o_tail} !== 4'b1100 ||
            bus_rr.o_flit !== 16'h0022)
            $display("FAIL single_body: v/vc/h/t=%b%b%b%b flit=%h, want 1100 0022",
                     bus_rr.o_valid, bus_rr.o_vc, bus_rr.o_head, bus_rr.o_tail, bus_rr.o_flit);
        else passes++;
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({bus_rr.o_valid, bus_rr.o_vc, bus_rr.o_head, bus_rr.o_tail} !== 4'b1101 ||
            bus_rr.o_flit !== 16'h0033)
            $display("FAIL single_tail: v/vc/h/t=%b%b%b%b flit=%h, want 1101 0033",
                     bus_rr.o_valid, bus_rr.o_vc, bus_rr.o_head, bus_rr.o_tail, bus_rr.o_flit);
        else passes++;
        step();
        checks++;
        if (bus_rr.o_valid !== 1'b0)
            $display("FAIL single_drained: valid=%b, want 0", bus_rr.o_valid);
        else passes++;
    endtask

    task automatic test_arbitration();
        logic [15:0] exp_rr [4];
        logic [15:0] exp_fp [4];
        exp_rr = '{16'h00a0, 16'h00b0, 16'h00a1, 16'h00b1};
        exp_fp = '{16'h00a0, 16'h00a1, 16'h00b0, 16'h00b1};
        do_reset();
        drive(1'b1, 2'd0, 1'b1, 1'b1, 16'h00a0); step();
        drive(1'b1, 2'd1, 1'b1, 1'b1, 16'h00b0); step();
        drive(1'b1, 2'd0, 1'b1, 1'b1, 16'h00a1); step();
        drive(1'b1, 2'd1, 1'b1, 1'b1, 16'h00b1); step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
        set_ready(1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus_rr.o_valid !== 1'b1 || bus_rr.o_flit !== exp_rr[k])
                $display("FAIL arb_rr[%0d]: valid=%b flit=%h, want 1 %h",
                         k, bus_rr.o_valid, bus_rr.o_flit, exp_rr[k]);
            else passes++;
            checks++;
            if (bus_fp.o_valid !== 1'b1 || bus_fp.o_flit !== exp_fp[k])
                $display("FAIL arb_fp[%0d]: valid=%b flit=%h, want 1 %h",
                         k, bus_fp.o_valid, bus_fp.o_flit, exp_fp[k]);
            else passes++;
            step();
        end
        checks++;
        if (bus_rr.o_valid !== 1'b0 || bus_fp.o_valid !== 1'b0)
            $display("FAIL arb_drained: rr=%b fp=%b, want 0 0", bus_rr.o_valid, bus_fp.o_valid);
        else passes++;
    endtask

    task automatic test_lock();
        logic [15:0] exp_flit [9];
        logic        exp_vc   [9];
        exp_flit = '{16'h0040, 16'h0041, 16'h0041, 16'h0042, 16'h0042,
                     16'h0043, 16'h0043, 16'h0050, 16'h0050};
        exp_vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        drive(1'b1, 2'd0, 1'b1, 1'b0, 16'h0040); step();
        drive(1'b1, 2'd0, 1'b0, 1'b0, 16'h0041); step();
        drive(1'b1, 2'd0, 1'b0, 1'b0, 16'h0042); step();
        drive(1'b1, 2'd0, 1'b0, 1'b1, 16'h0043); step();
        drive(1'b1, 2'd1, 1'b1, 1'b1, 16'h0050); step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 9; k++) begin
            set_ready(k % 2 == 0);
            checks++;
            if (bus_rr.o_valid !== 1'b1 || bus_rr.o_flit !== exp_flit[k] ||
                bus_rr.o_vc !== exp_vc[k])
                $display("FAIL lock[%0d]: valid=%b vc=%b flit=%h, want 1 %b %h",
                         k, bus_rr.o_valid, bus_rr.o_vc, bus_rr.o_flit, exp_vc[k], exp_flit[k]);
            else passes++;
            step();
        end
        checks++;
        if (bus_rr.o_valid !== 1'b0)
            $display("FAIL lock_drained: valid=%b, want 0", bus_rr.o_valid);
        else passes++;
    endtask

    task automatic test_full_threshold();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 2'd0, 1'b1, 1'b1, 16'(k));
            step();
            checks++;
            if (bus_rr.o_almost_full[0] !== (k >= 2) || bus_rr.o_ready[0] !== (k < 4) ||
                bus_rr.o_ready[1] !== 1'b1)
                $display("FAIL full_push%0d: af0=%b rdy0=%b rdy1=%b, want %b %b 1", k,
                         bus_rr.o_almost_full[0], bus_rr.o_ready[0], bus_rr.o_ready[1],
                         k >= 2, k < 4);
            else passes++;
        end
        drive(1'b1, 2'd0, 1'b1, 1'b1, 16'h0005);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
        set_ready(1'b1);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (bus_rr.o_valid !== 1'b1 || bus_rr.o_flit !== 16'(k))
                $display("FAIL full_drain%0d: valid=%b flit=%h, want 1 %h",
                         k, bus_rr.o_valid, bus_rr.o_flit, 16'(k));
            else passes++;
            step();
        end
        checks++;
        if (bus_rr.o_valid !== 1'b0 || bus_rr.o_ready !== 2'b11 || bus_rr.o_almost_full !== 2'b00)
            $display("FAIL full_refused5: valid=%b ready=%b af=%b, want 0 11 00",
                     bus_rr.o_valid, bus_rr.o_ready, bus_rr.o_almost_full);
        else passes++;
    endtask

    task automatic test_errors();
        do_reset();
        set_ready(1'b1);
        drive(1'b1, 2'd3, 1'b1, 1'b1, 16'h0099);
        checks++;
        if (bus_c3.o_error !== 1'b0)
            $display("FAIL err_vc_early: err=%b, want 0", bus_c3.o_error);
        else passes++;
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (bus_c3.o_error !== 1'b1 || bus_c3.o_valid !== 1'b0 || bus_c3.o_ready !== 3'b111 ||
            bus_c3.o_almost_full !== 3'b000)
            $display("FAIL err_vc_pulse: err=%b valid=%b ready=%b af=%b, want 1 0 111 000",
                     bus_c3.o_error, bus_c3.o_valid, bus_c3.o_ready, bus_c3.o_almost_full);
        else passes++;
        step();
        checks++;
        if (bus_c3.o_error !== 1'b0)
            $display("FAIL err_vc_once: err=%b, want 0", bus_c3.o_error);
        else passes++;

        do_reset();
        set_ready(1'b1);
        drive(1'b1, 2'd0, 1'b0, 1'b0, 16'h0077);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (bus_rr.o_valid !== 1'b0 || bus_rr.o_error !== 1'b0)
            $display("FAIL err_body_discard: valid=%b err=%b, want 0 0",
                     bus_rr.o_valid, bus_rr.o_error);
        else passes++;
        step();
        checks++;
        if (bus_rr.o_valid !== 1'b0 || bus_rr.o_error !== 1'b1)
            $display("FAIL err_body_pulse: valid=%b err=%b, want 0 1",
                     bus_rr.o_valid, bus_rr.o_error);
        else passes++;
        step();
        checks++;
        if (bus_rr.o_valid !== 1'b0 || bus_rr.o_error !== 1'b0)
            $display("FAIL err_body_once: valid=%b err=%b, want 0 0",
                     bus_rr.o_valid, bus_rr.o_error);
        else passes++;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_ready(1'b1);
        drive(1'b1, 2'd0, 1'b1, 1'b0, 16'h0060);
        step();
        drive(1'b1, 2'd0, 1'b0, 1'b0, 16'h0061);
        checks++;
        if (bus_rr.o_valid !== 1'b1 || bus_rr.o_flit !== 16'h0060)
            $display("FAIL rstmid_head: valid=%b flit=%h, want 1 0060",
                     bus_rr.o_valid, bus_rr.o_flit);
        else passes++;
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus_rr.o_valid, bus_rr.o_error, bus_rr.o_vc, bus_rr.o_head, bus_rr.o_tail}
            !== 5'b0 || bus_rr.o_flit !== 16'h0 || bus_rr.o_ready !== 2'b11 ||
            bus_rr.o_almost_full !== 2'b00)
            $display("FAIL rstmid_outputs: valid=%b flit=%h ready=%b af=%b, want 0 0000 11 00",
                     bus_rr.o_valid, bus_rr.o_flit, bus_rr.o_ready, bus_rr.o_almost_full);
        else passes++;
        #2;
        rst_n = 1'b1;
        drive(1'b1, 2'd1, 1'b1, 1'b1, 16'h0070);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({bus_rr.o_valid, bus_rr.o_vc, bus_rr.o_head, bus_rr.o_tail} !== 4'b1111 ||
            bus_rr.o_flit !== 16'h0070)
            $display("FAIL rstmid_fresh: v/vc/h/t=%b%b%b%b flit=%h, want 1111 0070",
                     bus_rr.o_valid, bus_rr.o_vc, bus_rr.o_head, bus_rr.o_tail, bus_rr.o_flit);
        else passes++;
        step();
        checks++;
        if (bus_rr.o_valid !== 1'b0 || bus_rr.o_error !== 1'b0)
            $display("FAIL rstmid_no_stale: valid=%b err=%b flit=%h, want 0 0",
                     bus_rr.o_valid, bus_rr.o_error, bus_rr.o_flit);
        else passes++;
    endtask

    initial begin
        drive(1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
        set_ready(1'b0);
        test_reset();
        test_single_vc();
        test_arbitration();
        test_lock();
        test_full_threshold();
        test_errors();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
